// File: rtl/ed25519_pkg.sv
// Shared Ed25519 field-element types and constants for the base-point table path.
// Vectors are numbered [0:FE_W-1]; limb i lives in bits [288-32i : 319-32i].
package ed25519_pkg;

  localparam int LIMB_W     = 32;
  localparam int NUM_LIMBS  = 10;
  localparam int FE_W       = 320;
  localparam int BI_ENTRIES = 8;

  typedef logic signed [0:FE_W-1] fe_t;

  // Limb 0 occupies the least-significant end, so a numeric 1 sets limb 0 to 1.
  localparam fe_t FE_ONE  = fe_t'(1);
  localparam fe_t FE_ZERO = '0;

  typedef enum logic [1:0] {IDLE, SCAN, FINAL, DONE} state_t;

endpackage

// File: rtl/bi_precomp_select_if.sv
// Request, table-ROM and result signals of the odd-multiple base-point selector.
interface bi_precomp_select_if #(parameter int FE_W = 320);

  logic              start;
  logic signed [4:0] digit;
  logic              busy;
  logic [3:0]        rom_index;
  logic [0:FE_W-1]   rom_yplus_x;
  logic [0:FE_W-1]   rom_yminus_x;
  logic [0:FE_W-1]   rom_z;
  logic [0:FE_W-1]   out_yplus_x;
  logic [0:FE_W-1]   out_yminus_x;
  logic [0:FE_W-1]   out_xy2d;
  logic              out_valid;
  logic              err;

  modport master (
    output start, digit, rom_yplus_x, rom_yminus_x, rom_z,
    input  busy, rom_index, out_yplus_x, out_yminus_x, out_xy2d, out_valid, err
  );

  modport slave (
    input  start, digit, rom_yplus_x, rom_yminus_x, rom_z,
    output busy, rom_index, out_yplus_x, out_yminus_x, out_xy2d, out_valid, err
  );

endinterface

// File: rtl/fe_neg.sv
// Per-limb 32-bit two's-complement negation of a field element, with no carry
// between limbs and no reduction.
module fe_neg
  import ed25519_pkg::*;
(
  input  fe_t a,
  output fe_t y
);

  for (genvar i = 0; i < NUM_LIMBS; i++) begin : g_limb
    assign y[FE_W-LIMB_W*(i+1) +: LIMB_W] = -a[FE_W-LIMB_W*(i+1) +: LIMB_W];
  end

endmodule

// File: rtl/bi_precomp_select.sv
// Constant-time selector: sweeps every table entry, keeps the one matching |digit|
// by mask, then conditionally negates the cached point.
module bi_precomp_select #(
  parameter int NUM_ENTRIES = 8,
  parameter int FE_W        = 320
) (
  input logic               clk,
  input logic               rst_n,
  bi_precomp_select_if.slave bus
);

  import ed25519_pkg::*;

  state_t          state, state_nxt;
  logic [3:0]      k;
  logic [3:0]      target;
  logic            neg;
  logic            zero;
  logic            illegal_q;
  logic [0:FE_W-1] acc_yp, acc_ym, acc_z;
  fe_t             z_neg;
  logic            hit, last;
  logic [4:0]      abs_d;
  logic            illegal_d;

  assign abs_d     = bus.digit[4] ? 5'(-bus.digit) : 5'(bus.digit);
  // Even digits (including 0 and -16) never select an entry; only nonzero ones are errors.
  assign illegal_d = !bus.digit[0] && (bus.digit != 5'sd0);
  assign last      = (k == 4'(NUM_ENTRIES - 1));
  assign hit       = !zero && (k == target);

  fe_neg u_neg (
    .a(acc_z),
    .y(z_neg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.busy      = (state != IDLE);
    bus.rom_index = '0;
    case (state)
      IDLE:  if (bus.start) state_nxt = SCAN;
      SCAN: begin
        bus.rom_index = k;
        if (last) state_nxt = FINAL;
      end
      FINAL: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k                <= '0;
      target           <= '0;
      neg              <= 1'b0;
      zero             <= 1'b0;
      illegal_q        <= 1'b0;
      acc_yp           <= '0;
      acc_ym           <= '0;
      acc_z            <= '0;
      bus.out_yplus_x  <= '0;
      bus.out_yminus_x <= '0;
      bus.out_xy2d     <= '0;
      bus.out_valid    <= 1'b0;
      bus.err          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          k         <= '0;
          neg       <= bus.digit[4];
          target    <= 4'((abs_d - 5'd1) >> 1);
          zero      <= !bus.digit[0];
          illegal_q <= illegal_d;
          acc_yp    <= FE_ONE;
          acc_ym    <= FE_ONE;
          acc_z     <= FE_ZERO;
        end
        SCAN: begin
          k <= last ? 4'd0 : k + 4'd1;
          if (hit) begin
            acc_yp <= bus.rom_yplus_x;
            acc_ym <= bus.rom_yminus_x;
            acc_z  <= bus.rom_z;
          end
        end
        FINAL: begin
          // Negating a cached point swaps y+x / y-x and negates xy2d.
          if (neg) begin
            bus.out_yplus_x  <= acc_ym;
            bus.out_yminus_x <= acc_yp;
            bus.out_xy2d     <= z_neg;
          end else begin
            bus.out_yplus_x  <= acc_yp;
            bus.out_yminus_x <= acc_ym;
            bus.out_xy2d     <= acc_z;
          end
          bus.out_valid <= 1'b1;
          bus.err       <= illegal_q;
        end
        DONE: begin
          bus.out_valid <= 1'b0;
          bus.err       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bi_precomp_select.sv
// Directed bench for bi_precomp_select: a behavioural table ROM, fixed-latency
// operations and immediate-assertion checks of results, timing and reset.
module tb_bi_precomp_select;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [319:0] exp_v;
  logic [319:0] tmp_v;

  bi_precomp_select_if #(.FE_W(320)) bus ();

  bi_precomp_select #(.NUM_ENTRIES(8), .FE_W(320)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table entry e, limb i: distinct recognisable patterns; entry 7 xy2d carries
  // the real limb 0 / limb 9 values used by the negation check.
  function automatic logic [319:0] rom_word(input logic [31:0] base, input int e);
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32*i +: 32] = base + 32'(e * 256 + i);
    return v;
  endfunction

  function automatic logic [319:0] rom_z_f(input int e);
    logic [319:0] v;
    v = rom_word(32'h3000_0000, e);
    if (e == 7) begin
      v[31:0]    = -32'sd3099351;
      v[319:288] = -32'sd12290683;
    end
    return v;
  endfunction

  always_comb begin
    bus.rom_yplus_x  = rom_word(32'h1000_0000, int'(bus.rom_index));
    bus.rom_yminus_x = rom_word(32'h2000_0000, int'(bus.rom_index));
    bus.rom_z        = rom_z_f(int'(bus.rom_index));
  end

  task automatic check_output(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a digit, check the full 10-cycle timeline, return in cycle T+11.
  // A nonzero poke issues an ignored start with digit -1 during T+3.
  task automatic apply_stimulus(input logic signed [4:0] d, input logic exp_err, input bit poke);
    bus.start = 1'b1;
    bus.digit = d;
    tick();
    bus.start = 1'b0;
    bus.digit = 5'sd0;
    for (int k = 0; k < 8; k++) begin
      check_output($sformatf("rom_index_k%0d", k), 320'(bus.rom_index), 320'(k));
      check_output($sformatf("busy_scan_k%0d", k), 320'(bus.busy), 320'(1));
      if (k == 0) check_output("valid_low_scan", 320'(bus.out_valid), 320'(0));
      if (poke && k == 2) begin
        bus.start = 1'b1;
        bus.digit = -5'sd1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    check_output("final_valid_low", 320'(bus.out_valid), 320'(0));
    check_output("final_rom_index", 320'(bus.rom_index), 320'(0));
    tick();
    check_output("t10_valid", 320'(bus.out_valid), 320'(1));
    check_output("t10_err", 320'(bus.err), 320'(exp_err));
    check_output("t10_busy", 320'(bus.busy), 320'(1));
    tick();
    check_output("t11_valid_low", 320'(bus.out_valid), 320'(0));
    check_output("t11_err_low", 320'(bus.err), 320'(0));
    check_output("t11_busy_low", 320'(bus.busy), 320'(0));
  endtask

  task automatic check_identity(input string tag);
    check_output({tag, "_yp"}, bus.out_yplus_x, 320'd1);
    check_output({tag, "_ym"}, bus.out_yminus_x, 320'd1);
    check_output({tag, "_xy2d"}, bus.out_xy2d, 320'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    bus.start = 1'b0;
    bus.digit = 5'sd0;
    rst_n     = 1'b0;
    #2;
    check_output("rst_busy", 320'(bus.busy), 320'(0));
    check_output("rst_valid", 320'(bus.out_valid), 320'(0));
    check_output("rst_err", 320'(bus.err), 320'(0));
    check_output("rst_rom_index", 320'(bus.rom_index), 320'(0));
    check_output("rst_out_yp", bus.out_yplus_x, 320'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] digit +1");
    apply_stimulus(5'sd1, 1'b0, 1'b0);
    check_output("p1_yp", bus.out_yplus_x, rom_word(32'h1000_0000, 0));
    check_output("p1_ym", bus.out_yminus_x, rom_word(32'h2000_0000, 0));
    check_output("p1_xy2d", bus.out_xy2d, rom_z_f(0));

    $display("[TB] digit -15");
    apply_stimulus(-5'sd15, 1'b0, 1'b0);
    check_output("m15_yp", bus.out_yplus_x, rom_word(32'h2000_0000, 7));
    check_output("m15_ym", bus.out_yminus_x, rom_word(32'h1000_0000, 7));
    tmp_v = bus.out_xy2d;
    check_output("m15_limb9", 320'(tmp_v[319:288]), 320'(32'd12290683));
    check_output("m15_limb0", 320'(tmp_v[31:0]), 320'(32'd3099351));
    exp_v = rom_z_f(7);
    for (int i = 0; i < 10; i++) exp_v[32*i +: 32] = -exp_v[32*i +: 32];
    check_output("m15_xy2d", bus.out_xy2d, exp_v);

    $display("[TB] digit 0");
    apply_stimulus(5'sd0, 1'b0, 1'b0);
    check_identity("zero");

    $display("[TB] digit +4 and -16");
    apply_stimulus(5'sd4, 1'b1, 1'b0);
    check_identity("p4");
    apply_stimulus(5'b10000, 1'b1, 1'b0);
    check_identity("m16");

    $display("[TB] start during busy, then back-to-back");
    apply_stimulus(5'sd3, 1'b0, 1'b1);
    check_output("p3_yp", bus.out_yplus_x, rom_word(32'h1000_0000, 1));
    check_output("p3_xy2d", bus.out_xy2d, rom_z_f(1));
    apply_stimulus(5'sd5, 1'b0, 1'b0);
    check_output("p5_yp", bus.out_yplus_x, rom_word(32'h1000_0000, 2));
    check_output("p5_ym", bus.out_yminus_x, rom_word(32'h2000_0000, 2));
    check_output("p5_xy2d", bus.out_xy2d, rom_z_f(2));

    $display("[TB] reset mid-scan");
    bus.start = 1'b1;
    bus.digit = -5'sd1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check_output("pre_rst_busy", 320'(bus.busy), 320'(1));
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_busy", 320'(bus.busy), 320'(0));
    check_output("mid_rst_rom_index", 320'(bus.rom_index), 320'(0));
    check_output("mid_rst_yp", bus.out_yplus_x, 320'd0);
    check_output("mid_rst_ym", bus.out_yminus_x, 320'd0);
    check_output("mid_rst_xy2d", bus.out_xy2d, 320'd0);
    for (int c = 0; c < 8; c++) begin
      tick();
      check_output($sformatf("rst_hold_valid_%0d", c), 320'(bus.out_valid), 320'(0));
    end
    rst_n = 1'b1;
    tick();
    check_output("post_rst_busy", 320'(bus.busy), 320'(0));
    apply_stimulus(5'sd7, 1'b0, 1'b0);
    check_output("p7_yp", bus.out_yplus_x, rom_word(32'h1000_0000, 3));
    check_output("p7_xy2d", bus.out_xy2d, rom_z_f(3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bi_precomp_select.md
# bi_precomp_select

Constant-time selector for the Ed25519 odd-multiple base-point table. It consumes the combinational `bi_constants_rom` outputs. Given a signed sliding-window digit, it scans all eight table entries, keeps the one matching |digit|, and applies conditional negation. It returns the cached point (y+x, y−x, xy2d) to the double-scalar-multiplication point adder downstream. Scan length is independent of digit value.

## Interface
Parameters:
- `NUM_ENTRIES`, default 8: table depth; the scan counter runs 0..NUM_ENTRIES−1.
- `FE_W`, default 320: field-element width, ten signed 32-bit limbs.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request. Sampled only when `busy`=0.
- `digit` in 5 (signed): window digit. Legal values are 0 and odd −15..15. Latched on accepted `start`.
- `busy` out 1: high from the cycle after accept until `out_valid` deasserts.
- `rom_index` out 4: address driven to the table ROM.
- `rom_yplus_x`, `rom_yminus_x`, `rom_z` in FE_W each: ROM data, combinational from `rom_index` in the same cycle.
- `out_yplus_x`, `out_yminus_x`, `out_xy2d` out FE_W each: selected cached point. Registered and held until the next accepted `start`.
- `out_valid` out 1: one-cycle pulse marking new result.
- `err` out 1: asserted with `out_valid` when the latched digit was illegal (even nonzero, or −16).

## Operation
- Limb packing: vectors are numbered [0:319]. Limb i occupies bits [288−32i : 319−32i]. Limb 0 is in [288:319]; limb 9 is in [0:31].
- On accept:
  - latch `neg` = digit<0.
  - latch `target` = (|digit|−1)>>1.
  - latch `zero` = (digit==0 or illegal).
  - load the accumulator with identity: yplus_x = yminus_x = limb0 1, all other limbs 0; xy2d = 0.
- States:
  - IDLE. Accepted `start` → SCAN with k=0.
  - SCAN. Drive `rom_index`=k. Compute `hit` = !zero && k==target. On `hit`, all three accumulators load the ROM data; otherwise they hold. Selection is mask-based with no early exit. k=NUM_ENTRIES−1 → FINAL, else k+1.
  - FINAL. If `neg`: out_yplus_x←acc_yminus_x, out_yminus_x←acc_yplus_x, out_xy2d←per-limb 32-bit two's-complement negation of acc_z. Otherwise copy the accumulators straight through. No carry propagation or reduction. Set `out_valid`, and set `err` if the digit was illegal → DONE.
  - DONE. Clear `out_valid`/`err` → IDLE.
- Illegal digit: the scan still runs all 8 cycles. The output is identity and `err`=1.
- `start` while `busy`=1: ignored, no queueing.
- `rom_index` is 0 outside SCAN.

## Timing
- Accept at cycle T. SCAN occupies T+1..T+8, with rom_index=k at T+1+k. FINAL is T+9.
- `out_valid`/`err` are high during T+10 only, and data is valid from T+10.
- `busy` is high T+1..T+10.
- Earliest next accept is T+11. Latency is fixed at 10 cycles for every digit.
- Reset values: all outputs 0, `busy`/`out_valid`/`err` 0, `rom_index` 0, state IDLE.
- Reset asserted mid-scan aborts immediately to these values. The partial result is discarded.

## Structure
- `ed25519_pkg` holds:
  - constants `LIMB_W`=32, `NUM_LIMBS`=10, `FE_W`=320, `BI_ENTRIES`=8.
  - `typedef logic signed [0:FE_W-1] fe_t`.
  - `FE_ONE` (limb0=1) and `FE_ZERO`.
  - the state enum {IDLE, SCAN, FINAL, DONE}.
- Sub-module `fe_neg`: combinational per-limb negation of one `fe_t`. It is reused by the point adder.
- The top level contains the FSM, the scan counter, the three accumulators and the output registers.

## Test plan
- digit=+1 → out = entry 0 unchanged, `out_valid` at T+10, `err`=0. Also check rom_index sequence 0..7 on T+1..T+8.
- digit=−15 → out_yplus_x = entry 7 yminus_x, out_yminus_x = entry 7 yplus_x. out_xy2d limb9 = +12290683 and limb0 = +3099351.
- digit=0 → identity (limb0 of yplus_x/yminus_x = 1, xy2d = 0). Latency is still 10 cycles and rom_index still sweeps 0..7.
- digit=+4 and digit=−16 → identity with `err`=1 in T+10.
- `start` pulsed at T+3 during busy → ignored. A back-to-back accept at T+11 with digit=+5 → entry 2 at T+21.
- `rst_n` low at T+5 → all outputs 0 asynchronously, no `out_valid`. After release, a new `start` completes normally.
